// File: rtl/ysyx_25040101_lsu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25040101_lsu_pkg
// Shared definitions for the load/store unit:
//   - FSM state encoding (IDLE/REQ/WAIT/DONE) as plain 2-bit constants
//   - op_e: internal memory-operation code produced from the decoder enables
//   - LANES: number of byte lanes on the data bus
//   - helpers: is_store(), is_misaligned()
// ---------------------------------------------------------------------------
package ysyx_25040101_lsu_pkg;

   localparam int LANES = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   typedef enum logic [2:0] {
      OP_LB_U = 3'd0,
      OP_LH_U = 3'd1,
      OP_LH_S = 3'd2,
      OP_LW   = 3'd3,
      OP_SB   = 3'd4,
      OP_SH   = 3'd5,
      OP_SW   = 3'd6
   } op_e;

   function automatic logic is_store(op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Half accesses must sit on an even byte, word accesses on a 4-byte boundary.
   function automatic logic is_misaligned(op_e op, logic [1:0] lo);
      case (op)
         OP_LH_U, OP_LH_S, OP_SH: return lo[0];
         OP_LW, OP_SW:            return lo != 2'b00;
         default:                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_25040101_lsu_if.sv
// ---------------------------------------------------------------------------
// ysyx_25040101_lsu_if
// Data-memory bus between the LSU (master) and memory (slave).
// Handshake: a request transfers on the cycle where req_valid_o && req_ready_i
// are both high at the rising clock edge; the master holds every req_* field
// stable while req_valid_o is high and ready is low. A response transfers on
// resp_valid_i && resp_ready_o at the rising edge; resp_rdata_i is only
// meaningful for reads (for writes the response is just an acknowledge).
//   req_valid_o  master->slave  request valid
//   req_ready_i  slave->master  request accepted
//   req_addr_o   master->slave  word-aligned byte address
//   req_wen_o    master->slave  1 = write
//   req_wdata_o  master->slave  lane-replicated store data
//   req_wstrb_o  master->slave  byte strobes (0 for reads)
//   resp_valid_i slave->master  response valid
//   resp_rdata_i slave->master  raw read word
//   resp_ready_o master->slave  master accepting response
// ---------------------------------------------------------------------------
interface ysyx_25040101_lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid_o;
   logic              req_ready_i;
   logic [ADDR_W-1:0] req_addr_o;
   logic              req_wen_o;
   logic [DATA_W-1:0] req_wdata_o;
   logic [3:0]        req_wstrb_o;
   logic              resp_valid_i;
   logic [DATA_W-1:0] resp_rdata_i;
   logic              resp_ready_o;

   modport master (
      output req_valid_o, req_addr_o, req_wen_o, req_wdata_o, req_wstrb_o, resp_ready_o,
      input  req_ready_i, resp_valid_i, resp_rdata_i
   );

   modport slave (
      input  req_valid_o, req_addr_o, req_wen_o, req_wdata_o, req_wstrb_o, resp_ready_o,
      output req_ready_i, resp_valid_i, resp_rdata_i
   );
endinterface

// File: rtl/ysyx_25040101_lsu_align.sv
// ---------------------------------------------------------------------------
// ysyx_25040101_lsu_align
// Purely combinational byte-lane logic shared by the store and load paths.
//   op_i        operation code
//   offset_i    low two address bits (byte offset inside the word)
//   wdata_i     rs2 store data
//   rdata_raw_i raw word returned by memory
//   wstrb_o     byte strobes for stores (0 for loads)
//   wdata_o     store data replicated onto every lane the access may hit
//   rdata_o     selected and zero/sign-extended load result (0 for stores)
// ---------------------------------------------------------------------------
module ysyx_25040101_lsu_align
   import ysyx_25040101_lsu_pkg::*;
(
   input  op_e               op_i,
   input  logic [1:0]        offset_i,
   input  logic [LANES*8-1:0] wdata_i,
   input  logic [LANES*8-1:0] rdata_raw_i,
   output logic [LANES-1:0]  wstrb_o,
   output logic [LANES*8-1:0] wdata_o,
   output logic [LANES*8-1:0] rdata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata_raw_i[{offset_i, 3'b000} +: 8];
   // Half selection uses only offset[1]; offset[0] is ignored so an odd half
   // address reads the half that contains it.
   assign half_sel = offset_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];

   always_comb begin
      wstrb_o = '0;
      wdata_o = '0;
      rdata_o = '0;
      case (op_i)
         OP_LB_U: rdata_o = {24'h0, byte_sel};
         OP_LH_U: rdata_o = {16'h0, half_sel};
         OP_LH_S: rdata_o = {{16{half_sel[15]}}, half_sel};
         OP_LW:   rdata_o = rdata_raw_i;
         OP_SB: begin
            wstrb_o = 4'b0001 << offset_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         OP_SH: begin
            wstrb_o = 4'b0011 << {offset_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
         end
         OP_SW: begin
            wstrb_o = 4'hF;
            wdata_o = wdata_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_25040101_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_25040101_lsu
// Load/store unit: turns the decoder's one-hot memory enables plus the ALU
// address and rs2 data into one request/response transaction on the data bus,
// then returns the aligned, extended load result with a one-cycle done pulse.
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   start_i             execute-stage request, sampled only in IDLE
//   read_*/write_*_en_i lbu/lhu/lh/lw and sb/sh/sw enables
//   addr_i, wdata_i     effective address and rs2 data
//   bus                 data-memory bus (master side of ysyx_25040101_lsu_if)
//   busy_o              transaction in flight (REQ or WAIT)
//   done_o              one-cycle completion pulse
//   rdata_o             load result, held until the next done (0 after stores)
//   err_o               misaligned-access flag, pulses with done_o
//   dbg_state_o         current FSM state
// Build option: YSYX_25040101_LSU_MISALIGN_CHECK_EN enables the misaligned
// access trap; without it err_o is tied low and every access goes to the bus.
// ---------------------------------------------------------------------------
module ysyx_25040101_lsu
   import ysyx_25040101_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              read_1B_mem_en_i,
   input  logic              read_2B_mem_en_i,
   input  logic              read_2B_sext_mem_en_i,
   input  logic              read_4B_mem_en_i,
   input  logic              write_1B_mem_en_i,
   input  logic              write_2B_mem_en_i,
   input  logic              write_4B_mem_en_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   ysyx_25040101_lsu_if.master bus,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o,
   output logic [1:0]        dbg_state_o
);

   logic [1:0]        state_q;
   op_e               op_q;
   logic [1:0]        offset_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic              req_wen_q;
   logic [DATA_W-1:0] req_wdata_q;
   logic [3:0]        req_wstrb_q;
   logic [DATA_W-1:0] rdata_q;

   op_e               op_dec;
   op_e               op_sel;
   logic [1:0]        offset_sel;
   logic              any_en;
   logic [3:0]        al_wstrb;
   logic [DATA_W-1:0] al_wdata;
   logic [DATA_W-1:0] al_rdata;

   // Several enables at once is illegal, but resolve it deterministically:
   // reads win over writes, wider wins over narrower.
   always_comb begin
      op_dec = OP_LW;
      if (read_4B_mem_en_i)           op_dec = OP_LW;
      else if (read_2B_sext_mem_en_i) op_dec = OP_LH_S;
      else if (read_2B_mem_en_i)      op_dec = OP_LH_U;
      else if (read_1B_mem_en_i)      op_dec = OP_LB_U;
      else if (write_4B_mem_en_i)     op_dec = OP_SW;
      else if (write_2B_mem_en_i)     op_dec = OP_SH;
      else if (write_1B_mem_en_i)     op_dec = OP_SB;
   end

   assign any_en = read_1B_mem_en_i | read_2B_mem_en_i | read_2B_sext_mem_en_i |
                   read_4B_mem_en_i | write_1B_mem_en_i | write_2B_mem_en_i |
                   write_4B_mem_en_i;

   // One align instance serves both paths: in IDLE it builds the store lanes
   // from the incoming request, afterwards it extracts the load from the
   // response using the latched op/offset.
   assign op_sel     = (state_q == S_IDLE) ? op_dec : op_q;
   assign offset_sel = (state_q == S_IDLE) ? addr_i[1:0] : offset_q;

   ysyx_25040101_lsu_align u_align (
      .op_i        (op_sel),
      .offset_i    (offset_sel),
      .wdata_i     (wdata_i),
      .rdata_raw_i (bus.resp_rdata_i),
      .wstrb_o     (al_wstrb),
      .wdata_o     (al_wdata),
      .rdata_o     (al_rdata)
   );

`ifdef YSYX_25040101_LSU_MISALIGN_CHECK_EN
   logic err_q;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         op_q        <= OP_LB_U;
         offset_q    <= 2'b00;
         req_addr_q  <= '0;
         req_wen_q   <= 1'b0;
         req_wdata_q <= '0;
         req_wstrb_q <= 4'h0;
         rdata_q     <= '0;
`ifdef YSYX_25040101_LSU_MISALIGN_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i && any_en) begin
                  op_q        <= op_dec;
                  offset_q    <= addr_i[1:0];
                  req_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                  req_wen_q   <= is_store(op_dec);
                  req_wdata_q <= al_wdata;
                  req_wstrb_q <= al_wstrb;
`ifdef YSYX_25040101_LSU_MISALIGN_CHECK_EN
                  // Misaligned accesses never reach the bus.
                  if (is_misaligned(op_dec, addr_i[1:0])) begin
                     state_q <= S_DONE;
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end else begin
                     state_q <= S_REQ;
                  end
`else
                  state_q     <= S_REQ;
`endif
               end
            end
            S_REQ: begin
               if (bus.req_ready_i) state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.resp_valid_i) begin
                  rdata_q <= req_wen_q ? '0 : al_rdata;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
`ifdef YSYX_25040101_LSU_MISALIGN_CHECK_EN
               err_q   <= 1'b0;
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs decode straight from registers; request fields are zero outside
   // REQ so the bus is quiet between transactions.
   assign bus.req_valid_o  = (state_q == S_REQ);
   assign bus.req_addr_o   = bus.req_valid_o ? req_addr_q  : '0;
   assign bus.req_wen_o    = bus.req_valid_o & req_wen_q;
   assign bus.req_wdata_o  = bus.req_valid_o ? req_wdata_q : '0;
   assign bus.req_wstrb_o  = bus.req_valid_o ? req_wstrb_q : 4'h0;
   assign bus.resp_ready_o = (state_q == S_WAIT);

   assign busy_o      = (state_q == S_REQ) || (state_q == S_WAIT);
   assign done_o      = (state_q == S_DONE);
   assign rdata_o     = rdata_q;
   assign dbg_state_o = state_q;

`ifdef YSYX_25040101_LSU_MISALIGN_CHECK_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25040101_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25040101_lsu
// Directed bench for the load/store unit. A transaction-level model predicts
// the bus request and the completion result of every access; a negedge
// compare process checks the DUT against it, and each directed vector also
// pins literal expected values.
// ---------------------------------------------------------------------------
module tb_ysyx_25040101_lsu;

`ifdef YSYX_25040101_LSU_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   // Bench op numbering doubles as the bit index in the enable mask.
   localparam int OP_LBU = 0;
   localparam int OP_LHU = 1;
   localparam int OP_LH  = 2;
   localparam int OP_LW  = 3;
   localparam int OP_SB  = 4;
   localparam int OP_SH  = 5;
   localparam int OP_SW  = 6;

   typedef struct packed {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } res_t;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        start;
   logic        r1, r2, r2s, r4, w1, w2, w4;
   logic [31:0] addr, wdata;
   logic        busy_o, done_o, err_o;
   logic [31:0] rdata_o;
   logic [1:0]  dbg_state;

   ysyx_25040101_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

   ysyx_25040101_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i                 (clk),
      .rst_n_i               (rst_n),
      .start_i               (start),
      .read_1B_mem_en_i      (r1),
      .read_2B_mem_en_i      (r2),
      .read_2B_sext_mem_en_i (r2s),
      .read_4B_mem_en_i      (r4),
      .write_1B_mem_en_i     (w1),
      .write_2B_mem_en_i     (w2),
      .write_4B_mem_en_i     (w4),
      .addr_i                (addr),
      .wdata_i               (wdata),
      .bus                   (bus_if),
      .busy_o                (busy_o),
      .done_o                (done_o),
      .rdata_o               (rdata_o),
      .err_o                 (err_o),
      .dbg_state_o           (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int          n_chk = 0;
   int          n_pass = 0;
   req_t        exp_req_q[$];
   res_t        exp_res_q[$];
   logic [31:0] held = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- model ----------------
   function automatic int eff_op(input logic [6:0] m);
      if (m[OP_LW])  return OP_LW;
      if (m[OP_LH])  return OP_LH;
      if (m[OP_LHU]) return OP_LHU;
      if (m[OP_LBU]) return OP_LBU;
      if (m[OP_SW])  return OP_SW;
      if (m[OP_SH])  return OP_SH;
      return OP_SB;
   endfunction

   function automatic bit misaligned(input int op, input logic [31:0] a);
      int o = int'(a[1:0]);
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return (o % 2) != 0;
      if (op == OP_LW || op == OP_SW) return o != 0;
      return 1'b0;
   endfunction

   function automatic req_t model_req(input int op, input logic [31:0] a, input logic [31:0] wd);
      req_t r;
      int   o = int'(a[1:0]);
      r.addr  = a - 32'(o);
      r.wen   = (op >= OP_SB);
      r.wdata = 32'h0;
      r.wstrb = 4'h0;
      if (op == OP_SB) begin
         r.wdata = (wd & 32'hFF) * 32'h0101_0101;
         r.wstrb = 4'(1 << o);
      end else if (op == OP_SH) begin
         r.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
         r.wstrb = 4'(3 << (2 * (o / 2)));
      end else if (op == OP_SW) begin
         r.wdata = wd;
         r.wstrb = 4'hF;
      end
      return r;
   endfunction

   function automatic res_t model_res(input int op, input logic [31:0] a, input logic [31:0] raw,
                                      input bit trap);
      res_t r;
      int   o = int'(a[1:0]);
      int   s;
      r.err   = trap;
      r.rdata = 32'h0;
      if (!trap) begin
         if (op == OP_LBU) r.rdata = (raw >> (8 * o)) & 32'hFF;
         else if (op == OP_LHU) r.rdata = (raw >> (16 * (o / 2))) & 32'hFFFF;
         else if (op == OP_LH) begin
            s = int'((raw >> (16 * (o / 2))) & 32'hFFFF);
            if (s >= 32768) s = s - 65536;
            r.rdata = 32'(s);
         end else if (op == OP_LW) r.rdata = raw;
      end
      return r;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_if.req_valid_o) begin
            if (exp_req_q.size() == 0) check("req_unexpected", 32'(bus_if.req_valid_o), 32'h0);
            else begin
               check("req_addr", bus_if.req_addr_o, exp_req_q[0].addr);
               check("req_wen", 32'(bus_if.req_wen_o), 32'(exp_req_q[0].wen));
               check("req_wstrb", 32'(bus_if.req_wstrb_o), 32'(exp_req_q[0].wstrb));
               if (exp_req_q[0].wen) check("req_wdata", bus_if.req_wdata_o, exp_req_q[0].wdata);
               if (bus_if.req_ready_i) void'(exp_req_q.pop_front());
            end
         end
         if (done_o) begin
            if (exp_res_q.size() == 0) check("done_unexpected", 32'(done_o), 32'h0);
            else begin
               check("done_rdata", rdata_o, exp_res_q[0].rdata);
               check("done_err", 32'(err_o), 32'(exp_res_q[0].err));
               held = exp_res_q[0].rdata;
               void'(exp_res_q.pop_front());
            end
         end else begin
            check("rdata_held", rdata_o, held);
            check("err_quiet", 32'(err_o), 32'h0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_en(input logic [6:0] m);
      r1 = m[OP_LBU]; r2 = m[OP_LHU]; r2s = m[OP_LH]; r4 = m[OP_LW];
      w1 = m[OP_SB];  w2 = m[OP_SH];  w4 = m[OP_SW];
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req_valid"}, 32'(bus_if.req_valid_o), 32'h0);
      check({tag, "_req_addr"}, bus_if.req_addr_o, 32'h0);
      check({tag, "_req_wen"}, 32'(bus_if.req_wen_o), 32'h0);
      check({tag, "_req_wstrb"}, 32'(bus_if.req_wstrb_o), 32'h0);
      check({tag, "_resp_ready"}, 32'(bus_if.resp_ready_o), 32'h0);
      check({tag, "_busy"}, 32'(busy_o), 32'h0);
      check({tag, "_done"}, 32'(done_o), 32'h0);
      check({tag, "_rdata"}, rdata_o, 32'h0);
      check({tag, "_err"}, 32'(err_o), 32'h0);
   endtask

   // Called just after a rising edge; returns latency from start cycle to done.
   task automatic run_txn(input logic [6:0] mask, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] raw, input int rdy_dly, input int resp_dly,
                          input bit poke, output int lat, output logic [31:0] rd,
                          output logic er, output req_t seen);
      int op;
      bit trap;
      int t0;
      int n;
      op   = eff_op(mask);
      trap = MIS_EN && misaligned(op, a);
      if (!trap) exp_req_q.push_back(model_req(op, a, wd));
      exp_res_q.push_back(model_res(op, a, raw, trap));
      seen  = '0;
      start = 1'b1; set_en(mask); addr = a; wdata = wd; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0; set_en(7'h0);
      if (!trap) begin
         for (int i = 0; i < rdy_dly; i++) begin
            check("stall_req_valid", 32'(bus_if.req_valid_o), 32'h1);
            check("stall_busy", 32'(busy_o), 32'h1);
            if (poke) begin
               start = 1'b1; set_en(7'h08);
               bus_if.resp_valid_i = 1'b1; bus_if.resp_rdata_i = 32'hBAD0_BAD0;
            end
            @(posedge clk); #1;
            start = 1'b0; set_en(7'h0); bus_if.resp_valid_i = 1'b0;
         end
         seen.addr  = bus_if.req_addr_o;
         seen.wen   = bus_if.req_wen_o;
         seen.wdata = bus_if.req_wdata_o;
         seen.wstrb = bus_if.req_wstrb_o;
         bus_if.req_ready_i = 1'b1;
         @(posedge clk); #1;
         bus_if.req_ready_i = 1'b0;
         for (int i = 0; i < resp_dly; i++) begin
            check("wait_resp_ready", 32'(bus_if.resp_ready_o), 32'h1);
            check("wait_busy", 32'(busy_o), 32'h1);
            if (poke) begin start = 1'b1; set_en(7'h08); end
            @(posedge clk); #1;
            start = 1'b0; set_en(7'h0);
         end
         bus_if.resp_valid_i = 1'b1; bus_if.resp_rdata_i = raw;
         @(posedge clk); #1;
         bus_if.resp_valid_i = 1'b0; bus_if.resp_rdata_i = 32'h0;
      end
      n = 0;
      while (!done_o && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done_o) check("done_timeout", 32'(done_o), 32'h1);
      lat = cyc - t0;
      rd  = rdata_o;
      er  = err_o;
      check("done_not_busy", 32'(busy_o), 32'h0);
      if (poke) begin start = 1'b1; set_en(7'h08); end
      @(posedge clk); #1;
      start = 1'b0; set_en(7'h0);
      check("done_single_pulse", 32'(done_o), 32'h0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      req_t        sn;

      start = 1'b0; set_en(7'h0); addr = 32'h0; wdata = 32'h0;
      bus_if.req_ready_i = 1'b0; bus_if.resp_valid_i = 1'b0; bus_if.resp_rdata_i = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // lw, minimum latency
      run_txn(7'h08, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, lat, rd, er, sn);
      check("lw_latency", 32'(lat), 32'd3);
      check("lw_rdata", rd, 32'hDEAD_BEEF);
      check("lw_req_addr", sn.addr, 32'h8000_0004);
      check("lw_wstrb", 32'(sn.wstrb), 32'h0);
      check("lw_wen", 32'(sn.wen), 32'h0);

      // lh / lhu on the upper half
      run_txn(7'h04, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 0, 1'b0, lat, rd, er, sn);
      check("lh_rdata", rd, 32'hFFFF_8001);
      run_txn(7'h02, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 0, 1'b0, lat, rd, er, sn);
      check("lhu_rdata", rd, 32'h0000_8001);

      // lbu, inner and top lanes
      run_txn(7'h01, 32'h8000_0001, 32'h0, 32'h1122_3344, 0, 1, 1'b0, lat, rd, er, sn);
      check("lbu1_rdata", rd, 32'h0000_0033);
      run_txn(7'h01, 32'h8000_0003, 32'h0, 32'hAABB_CCDD, 1, 0, 1'b0, lat, rd, er, sn);
      check("lbu3_rdata", rd, 32'h0000_00AA);

      // sb at offset 3
      run_txn(7'h10, 32'h8000_0013, 32'h1234_56AB, 32'hFFFF_FFFF, 0, 0, 1'b0, lat, rd, er, sn);
      check("sb_req_addr", sn.addr, 32'h8000_0010);
      check("sb_wstrb", 32'(sn.wstrb), 32'h8);
      check("sb_wdata", sn.wdata, 32'hABAB_ABAB);
      check("sb_wen", 32'(sn.wen), 32'h1);
      check("sb_rdata", rd, 32'h0);

      // sh upper half
      run_txn(7'h20, 32'h8000_0006, 32'h0000_BEEF, 32'h1234_5678, 0, 0, 1'b0, lat, rd, er, sn);
      check("sh_wstrb", 32'(sn.wstrb), 32'hC);
      check("sh_wdata", sn.wdata, 32'hBEEF_BEEF);

      // sw with request and response stalls, stray starts and an early response
      run_txn(7'h40, 32'h8000_0020, 32'hCAFE_F00D, 32'h0, 3, 2, 1'b1, lat, rd, er, sn);
      check("sw_latency", 32'(lat), 32'd8);
      check("sw_wstrb", 32'(sn.wstrb), 32'hF);
      check("sw_wdata", sn.wdata, 32'hCAFE_F00D);
      for (int i = 0; i < 3; i++) begin
         check("after_sw_idle_valid", 32'(bus_if.req_valid_o), 32'h0);
         check("after_sw_idle_busy", 32'(busy_o), 32'h0);
         @(posedge clk); #1;
      end

      // priority between simultaneous enables
      run_txn(7'h18, 32'h8000_0008, 32'h5555_5555, 32'h0102_0304, 0, 0, 1'b0, lat, rd, er, sn);
      check("prio_lw_wen", 32'(sn.wen), 32'h0);
      check("prio_lw_rdata", rd, 32'h0102_0304);
      run_txn(7'h30, 32'h8000_0002, 32'h0000_1234, 32'h0, 0, 0, 1'b0, lat, rd, er, sn);
      check("prio_sh_wstrb", 32'(sn.wstrb), 32'hC);
      check("prio_sh_wdata", sn.wdata, 32'h1234_1234);

      // misaligned word load
      run_txn(7'h08, 32'h8000_0002, 32'h0, 32'h7654_3210, 0, 0, 1'b0, lat, rd, er, sn);
      check("mis_lw_latency", 32'(lat), MIS_EN ? 32'd1 : 32'd3);
      check("mis_lw_err", 32'(er), MIS_EN ? 32'h1 : 32'h0);
      check("mis_lw_rdata", rd, MIS_EN ? 32'h0 : 32'h7654_3210);
      check("mis_lw_req_addr", sn.addr, MIS_EN ? 32'h0 : 32'h8000_0000);

      // half store at offset 3 uses lanes 3:2
      run_txn(7'h20, 32'h8000_0003, 32'h0000_A5A5, 32'h0, 0, 0, 1'b0, lat, rd, er, sn);
      check("sh3_err", 32'(er), MIS_EN ? 32'h1 : 32'h0);
      check("sh3_wstrb", 32'(sn.wstrb), MIS_EN ? 32'h0 : 32'hC);

      // start without any enable is ignored
      start = 1'b1; set_en(7'h0); addr = 32'h8000_0000;
      @(posedge clk); #1;
      start = 1'b0;
      check("noen_busy", 32'(busy_o), 32'h0);
      check("noen_valid", 32'(bus_if.req_valid_o), 32'h0);
      @(posedge clk); #1;
      check("noen_done", 32'(done_o), 32'h0);

      // reset in WAIT aborts; a stale response afterwards must not complete
      exp_req_q.push_back(model_req(OP_LW, 32'h8000_0008, 32'h0));
      exp_res_q.push_back(model_res(OP_LW, 32'h8000_0008, 32'h0, 1'b0));
      start = 1'b1; set_en(7'h08); addr = 32'h8000_0008;
      @(posedge clk); #1;
      start = 1'b0; set_en(7'h0);
      bus_if.req_ready_i = 1'b1;
      @(posedge clk); #1;
      bus_if.req_ready_i = 1'b0;
      check("abort_in_wait", 32'(bus_if.resp_ready_o), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check_zero("abort");
      exp_req_q.delete();
      exp_res_q.delete();
      held = 32'h0;
      bus_if.resp_valid_i = 1'b1; bus_if.resp_rdata_i = 32'h5555_AAAA;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("stale_resp_done", 32'(done_o), 32'h0);
         check("stale_resp_busy", 32'(busy_o), 32'h0);
      end
      bus_if.resp_valid_i = 1'b0; bus_if.resp_rdata_i = 32'h0;

      // recovery: positive half stays unsigned-looking
      run_txn(7'h04, 32'h8000_0000, 32'h0, 32'hFFFF_7FFF, 0, 0, 1'b0, lat, rd, er, sn);
      check("lh_pos_rdata", rd, 32'h0000_7FFF);
      check("lh_pos_latency", 32'(lat), 32'd3);

      repeat (2) @(posedge clk);
      #1;
      check("exp_req_drained", 32'(exp_req_q.size()), 32'h0);
      check("exp_res_drained", 32'(exp_res_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ysyx_25040101_lsu.md
Name: ysyx_25040101_lsu

Overview:
Load/store unit directly downstream of the instruction decoder. It consumes the decoder's seven one-hot memory enables plus the ALU-computed address and rs2 data. It then runs a single request/response transaction on the data-memory bus and returns the aligned, extended load result to writeback with a done pulse. The core stalls on busy_o.

Parameters:
ADDR_W, 32, byte address width of the bus and of addr_i
DATA_W, 32, data width; fixed at 32 (the byte-lane logic assumes 4 lanes)

Ports:
clk_i  in  1  core clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  execute-stage request; sampled only in IDLE
read_1B_mem_en_i / read_2B_mem_en_i / read_2B_sext_mem_en_i / read_4B_mem_en_i  in  1 each  lbu / lhu / lh / lw
write_1B_mem_en_i / write_2B_mem_en_i / write_4B_mem_en_i  in  1 each  sb / sh / sw
addr_i  in  ADDR_W  effective address (ALU result)
wdata_i  in  DATA_W  rs2 data
req_valid_o  out  1  bus request valid
req_ready_i  in  1  bus request accepted
req_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
req_wen_o  out  1  1 = write
req_wdata_o  out  DATA_W  lane-replicated store data
req_wstrb_o  out  4  byte strobes (0 for reads)
resp_valid_i  in  1  response valid (read data or write ack)
resp_rdata_i  in  DATA_W  raw read word
resp_ready_o  out  1  accepting response
busy_o  out  1  transaction in flight (start_i ignored)
done_o  out  1  one-cycle completion pulse
rdata_o  out  DATA_W  extended load result, valid with done_o, held until next done
err_o  out  1  misaligned-access flag, pulses with done_o (macro only)

Behaviour:
- Reset (async, rst_n_i=0): state IDLE. All outputs 0: req_*, resp_ready_o, busy_o, done_o, rdata_o, err_o. Latched operation is cleared. Reset during REQ/WAIT aborts the transaction with no done pulse.
- Enable priority if more than one is set (illegal, but defined): read4 > read2s > read2 > read1 > write4 > write2 > write1.
- IDLE: if start_i && any enable -> latch op, addr, wdata; go REQ. start_i with no enable is ignored. busy_o=0.
- REQ: req_valid_o=1, busy_o=1. All req_* outputs are registered and stable until req_ready_i. On req_valid_o && req_ready_i -> WAIT.
- WAIT: resp_ready_o=1, busy_o=1. On resp_valid_i -> capture and extend data, go DONE. A resp_valid_i seen while in REQ is ignored.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE. A start_i in DONE is ignored.
- Minimum latency: start at cycle T; req_valid_o at T+1; if ready at T+1 and resp at T+2, done_o at T+3.
- Store lanes (o = addr[1:0]):
  - sb: wstrb=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - sh: wstrb=4'b0011<<{o[1],1'b0}, wdata={2{wdata[15:0]}}.
  - sw: wstrb=4'hF.
  - Writes update rdata_o to 0 at done.
- Load extract:
  - lbu: zero-extend byte o.
  - lhu: zero-extend half o[1].
  - lh: sign-extend half o[1].
  - lw: whole word.

Optional Feature:
Macro YSYX_25040101_LSU_MISALIGN_CHECK_EN.
- With it: a half access with addr[0]=1, or a word access with addr[1:0]!=0, skips REQ/WAIT entirely. IDLE -> DONE, done_o=1, err_o=1, rdata_o=0, no bus activity.
- Without it: err_o is tied to 0. Low address bits select lanes as above (sh at o=3 uses lanes 3:2), and the access proceeds.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3); op encoding (3-bit LB_U, LH_U, LH_S, LW, SB, SH, SW); lane-count constant 4.
- One sub-module: ysyx_25040101_lsu_align. It is combinational: store strobe/replication and load extract/extension, shared by both paths. FSM and registers stay in the top.

Test Plan:
- lw at 0x8000_0004 with req_ready_i=1 and resp at the next cycle, rdata 0xDEAD_BEEF -> req_addr 0x8000_0004, wstrb 0, done_o at T+3, rdata_o=0xDEAD_BEEF.
- lh at 0x8000_0002, resp 0x8001_1234 -> rdata_o=0xFFFF_8001. lhu at the same address -> 0x0000_8001.
- sb at 0x8000_0013, wdata 0x1234_56AB -> req_addr 0x8000_0010, wstrb 4'b1000, wdata 0xABAB_ABAB, req_wen_o=1.
- sw with req_ready_i low for 3 cycles, then resp_valid_i delayed 2 cycles -> req_* stable throughout, busy_o=1, single done pulse. A start_i pulsed while busy is ignored.
- Assert rst_n_i low during WAIT -> all outputs 0 immediately. After release with a stale resp_valid_i: no done_o.
- With the macro, lw at 0x8000_0002 -> no req_valid_o, done_o=1 and err_o=1 at T+1, rdata_o=0. Without the macro -> a normal transaction, err_o=0.
